pcie_tl_req_splitter: RTL

//  Converts AXI AW/AR bursts into PCIe MemWr (posted) / MemRd (non-posted) request headers for the TL TX path.

---
 rtl/pcie_tl_req_splitter_pkg.sv | 71 +++++++
 rtl/pcie_tl_req_splitter_chunk_calc.sv | 30 +++
 rtl/pcie_tl_req_splitter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pcie_tl_req_splitter_pkg.sv
// Shared types and helpers for the PCIe TL request splitter: memory request
// header layout, header builders (3DW/4DW aware) and the MPS/MRRS decoder.
package pcie_tl_req_splitter_pkg;

    localparam int PAGE_BYTES = 4096;

    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [2:0] FMT_4DW_DATA   = 3'b011;
    localparam logic [4:0] TYPE_MEM       = 5'b00000;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  pkt_type;
        logic [9:0]  tag;
        logic [9:0]  length;        // DW count, 0 encodes 1024
        logic [15:0] requester_id;
        logic [3:0]  last_be;
        logic [3:0]  first_be;
        logic [63:0] addr;          // bits [1:0] always zero
    } tlp_memory_req_hdr_t;

    // Size code to bytes (128 << code), limited by the build-time ceiling.
    function automatic logic [12:0] mps_code_to_bytes(input logic [2:0]  code,
                                                      input int unsigned ceiling);
        int unsigned bytes;
        bytes = 32'd128 << code;
        if (bytes > ceiling) begin
            bytes = ceiling;
        end
        return bytes[12:0];
    endfunction

    // Single-DW requests must carry a zero last byte enable.
    function automatic logic [3:0] last_be_for(input logic [9:0] len_dw);
        return (len_dw == 10'd1) ? 4'h0 : 4'hF;
    endfunction

    function automatic tlp_memory_req_hdr_t gen_tlp_memwr_hdr(input logic [63:0] addr,
                                                              input logic [9:0]  len_dw,
                                                              input logic [15:0] req_id);
        tlp_memory_req_hdr_t hdr;
        hdr.fmt          = (addr[63:32] != 32'd0) ? FMT_4DW_DATA : FMT_3DW_DATA;
        hdr.pkt_type     = TYPE_MEM;
        hdr.tag          = '0;
        hdr.length       = len_dw;
        hdr.requester_id = req_id;
        hdr.last_be      = last_be_for(len_dw);
        hdr.first_be     = 4'hF;
        hdr.addr         = addr;
        return hdr;
    endfunction

    function automatic tlp_memory_req_hdr_t gen_tlp_memrd_hdr(input logic [63:0] addr,
                                                              input logic [9:0]  len_dw,
                                                              input logic [15:0] req_id,
                                                              input logic [9:0]  tag);
        tlp_memory_req_hdr_t hdr;
        hdr.fmt          = (addr[63:32] != 32'd0) ? FMT_4DW_NODATA : FMT_3DW_NODATA;
        hdr.pkt_type     = TYPE_MEM;
        hdr.tag          = tag;
        hdr.length       = len_dw;
        hdr.requester_id = req_id;
        hdr.last_be      = last_be_for(len_dw);
        hdr.first_be     = 4'hF;
        hdr.addr         = addr;
        return hdr;
    endfunction

endpackage

// File: rtl/pcie_tl_req_splitter_chunk_calc.sv
// Combinational chunk sizing: the next TLP covers the smallest of the bytes
// left in the burst, the negotiated size limit and the room left in the page.
module pcie_tl_chunk_calc
    import pcie_tl_req_splitter_pkg::*;
#(
    parameter int REM_W = 14
) (
    input  logic [REM_W-1:0] rem_i,
    input  logic [12:0]      max_i,
    input  logic [11:0]      addr_lo_i,
    output logic [REM_W-1:0] chunk_o,
    output logic [9:0]       len_dw_o,
    output logic             is_last_o
);

    logic [REM_W-1:0] page_rem;
    logic [REM_W-1:0] max_ext;
    logic [REM_W-1:0] limit;

    // Three-way minimum; a full 4 KB chunk drops to 10'd0 in the DW field.
    always_comb begin
        page_rem  = REM_W'(13'(PAGE_BYTES) - {1'b0, addr_lo_i});
        max_ext   = REM_W'(max_i);
        limit     = (max_ext < page_rem) ? max_ext : page_rem;
        chunk_o   = (rem_i < limit) ? rem_i : limit;
        len_dw_o  = chunk_o[11:2];
        is_last_o = (rem_i == chunk_o);
    end

endmodule

// File: rtl/pcie_tl_req_splitter.sv
// AXI AW/AR burst to PCIe MemWr/MemRd header splitter. One burst is held at
// a time; each cycle the issue condition holds, one TLP header is pushed and
// the captured address/remaining count advance by the chunk size.
module pcie_tl_req_splitter
    import pcie_tl_req_splitter_pkg::*;
#(
    parameter int AXI_ID_WIDTH      = 4,
    parameter int AXI_ADDR_WIDTH    = 64,
    parameter int AXI_DATA_BYTES    = 32,
    parameter int MAX_PAYLOAD_SIZE  = 512,
    parameter int MAX_READ_REQ_SIZE = 4096,
    parameter int ARB_MODE          = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [15:0]               config_bdf_i,
    input  logic [2:0]                cfg_mps_i,
    input  logic [2:0]                cfg_mrrs_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]                aw_len_i,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
    input  logic                      ar_valid_i,
    output logic                      ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]                ar_len_i,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id_i,
    input  logic                      p_hdr_full_i,
    input  logic                      np_hdr_full_i,
    output tlp_memory_req_hdr_t       p_hdr_o,
    output tlp_memory_req_hdr_t       np_hdr_o,
    output logic                      p_hdr_wren_o,
    output logic                      np_hdr_wren_o,
    input  logic                      tag_valid_i,
    input  logic [9:0]                tag_allocate_i,
    output logic                      tag_wren_o,
    output logic [9:0]                tag_length_o,
    output logic [AXI_ID_WIDTH-1:0]   tag_id_o,
    output logic                      writer_wren_o,
    output logic [9:0]                writer_len_o,
    input  logic                      writer_full_i,
    output logic                      busy_o
);

    // Wide enough for a full 256-beat burst and for a 4 KB chunk.
    localparam int REM_W = (256 * AXI_DATA_BYTES >= PAGE_BYTES) ?
                           $clog2(256 * AXI_DATA_BYTES) + 1 : 13;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WR_SPLIT = 2'd1;
    localparam logic [1:0] ST_RD_SPLIT = 2'd2;

    logic [1:0]              state_q,  state_d;
    logic [63:0]             addr_q,   addr_d;
    logic [REM_W-1:0]        rem_q,    rem_d;
    logic [12:0]             max_q,    max_d;
    logic [AXI_ID_WIDTH-1:0] id_q,     id_d;
    logic                    rr_ptr_q, rr_ptr_d;   // 0: write preferred next

    logic [REM_W-1:0] chunk;
    logic [9:0]       len_dw;
    logic             is_last;

    logic issue_wr, issue_rd, issue, can_grant, pick_wr, grant_wr, grant_rd;

    pcie_tl_chunk_calc #(
        .REM_W (REM_W)
    ) u_chunk_calc (
        .rem_i     (rem_q),
        .max_i     (max_q),
        .addr_lo_i (addr_q[11:0]),
        .chunk_o   (chunk),
        .len_dw_o  (len_dw),
        .is_last_o (is_last)
    );

    // Issue and grant decisions; a new burst may be taken while the last
    // chunk of the current one goes out, so bursts run back to back.
    always_comb begin
        issue_wr  = rst_n && (state_q == ST_WR_SPLIT) && !p_hdr_full_i && !writer_full_i;
        issue_rd  = rst_n && (state_q == ST_RD_SPLIT) && !np_hdr_full_i && tag_valid_i;
        issue     = issue_wr || issue_rd;
        can_grant = rst_n && ((state_q == ST_IDLE) || (issue && is_last));
        if (aw_valid_i && ar_valid_i) begin
            pick_wr = (ARB_MODE == 0) ? 1'b1 : !rr_ptr_q;
        end else begin
            pick_wr = aw_valid_i;
        end
        grant_wr  = can_grant && aw_valid_i && pick_wr;
        grant_rd  = can_grant && ar_valid_i && !pick_wr;
    end

    // Next-state: advance on issue, reload on grant, otherwise hold (stall).
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        max_d    = max_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            addr_d = addr_q + 64'(chunk);
            rem_d  = rem_q - chunk;
            if (is_last) begin
                state_d = ST_IDLE;
            end
        end
        if (grant_wr) begin
            state_d  = ST_WR_SPLIT;
            addr_d   = 64'(aw_addr_i);
            rem_d    = REM_W'((32'(aw_len_i) + 32'd1) * AXI_DATA_BYTES);
            max_d    = mps_code_to_bytes(cfg_mps_i, MAX_PAYLOAD_SIZE);
            id_d     = aw_id_i;
            rr_ptr_d = 1'b1;
        end else if (grant_rd) begin
            state_d  = ST_RD_SPLIT;
            addr_d   = 64'(ar_addr_i);
            rem_d    = REM_W'((32'(ar_len_i) + 32'd1) * AXI_DATA_BYTES);
            max_d    = mps_code_to_bytes(cfg_mrrs_i, MAX_READ_REQ_SIZE);
            id_d     = ar_id_i;
            rr_ptr_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset mid-burst drops the rest.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            max_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            max_q    <= max_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Outputs are combinational from registered state, so headers stay
    // stable for as long as a stall holds the registers.
    always_comb begin
        aw_ready_o    = grant_wr;
        ar_ready_o    = grant_rd;
        p_hdr_wren_o  = issue_wr;
        writer_wren_o = issue_wr;
        np_hdr_wren_o = issue_rd;
        tag_wren_o    = issue_rd;
        writer_len_o  = len_dw;
        tag_length_o  = len_dw;
        tag_id_o      = id_q;
        p_hdr_o       = gen_tlp_memwr_hdr(addr_q, len_dw, config_bdf_i);
        np_hdr_o      = gen_tlp_memrd_hdr(addr_q, len_dw, config_bdf_i, tag_allocate_i);
        busy_o        = (state_q != ST_IDLE);
    end

    a_aw_dw_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        aw_valid_i |-> aw_addr_i[1:0] == 2'b00);
    a_ar_dw_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        ar_valid_i |-> ar_addr_i[1:0] == 2'b00);

endmodule
